// File: rtl/glan_link_status_mon.sv
// glan_link_status_mon: synchronises, debounces and decodes per-port PHY LED pins into
// link speed, link-up, stretched activity and a sticky, maskable link-change interrupt.
module glan_link_status_mon #(
   parameter int DEB_CNT  = 33000,
   parameter int ACT_HOLD = 1650000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ALL_PWRGD,
   input  logic [1:0] PActivity,
   input  logic [1:0] Speed1P,
   input  logic [1:0] Speed2P,
   input  logic       IntEn,
   input  logic [1:0] IntClr,
   output logic [3:0] LinkSpeed,
   output logic [1:0] LinkUp,
   output logic [1:0] ActSeen,
   output logic [1:0] LinkChg,
   output logic       LinkIrq
);
   localparam int CW = $clog2(DEB_CNT);
   localparam int AW = $clog2(ACT_HOLD + 1);
   logic [5:0] sync_d, sync_q;
   logic [1:0] commit, act_nz;
   logic       clr_state;
   assign clr_state = Reset || !ALL_PWRGD;
   always_ff @(posedge Clk)
      if (Reset) begin
         sync_d <= '1;
         sync_q <= '1;
      end else begin
         sync_d <= {PActivity, Speed1P, Speed2P};
         sync_q <= sync_d;
      end
   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [1:0]    code, cand, stable;
      logic [CW-1:0] cnt;
      logic [AW-1:0] act;
      logic          sat;
      assign code   = {sync_q[2+p], sync_q[p]};
      assign sat    = cnt == CW'(DEB_CNT - 1);
      assign commit[p] = code == cand && sat && cand != stable;
      assign act_nz[p] = act != '0;
      always_ff @(posedge Clk)
         if (clr_state) begin
            cand   <= 2'b11;
            cnt    <= '0;
            stable <= 2'b11;
            act    <= '0;
         end else begin
            if (code != cand) begin
               cand <= code;
               cnt  <= '0;
            end else if (!sat)
               cnt <= cnt + 1'b1;
            else
               stable <= cand;
            act <= !sync_q[4+p] ? AW'(ACT_HOLD) : (act != '0 ? act - 1'b1 : act);
         end
      // 11 on the pins means no link; 00 is a code the controller never drives
      assign LinkSpeed[2*p+1:2*p] = stable == 2'b01 ? 2'b10 :
                                    stable == 2'b10 ? 2'b01 :
                                    stable == 2'b11 ? 2'b00 : 2'b11;
      assign LinkUp[p] = stable[1] ^ stable[0];
   end
   always_ff @(posedge Clk)
      if (Reset)
         LinkChg <= '0;
      else
         LinkChg <= (LinkChg & ~IntClr) | (commit & {2{ALL_PWRGD}});
   always_ff @(posedge Clk)
      if (clr_state)
         ActSeen <= '0;
      else
         ActSeen <= act_nz & LinkUp;
   assign LinkIrq = IntEn & |LinkChg;
endmodule

// File: doc/glan_link_status_mon.md
# glan_link_status_mon

Per-port link-status monitor for the 2-port Ethernet daughter board. It samples the active-low PHY LED pins driven by the LAN controller (ACT#, LINK1000#, LINK100#), which are also routed to the front-panel LED logic. It synchronises, debounces and decodes them into registered link-speed, link-up and activity status for the board management register file. It also raises a maskable interrupt on every debounced link change.

## Interface
- DEB_CNT, 33000: consecutive stable cycles required to commit a speed code (≈1 ms at 33 MHz); ≥2.
- ACT_HOLD, 1650000: activity stretch length in cycles (≈50 ms); ≥1.
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ALL_PWRGD  in  1  all power good; low = ports treated as absent.
- PActivity  in  2  ACT# per port, active low, asynchronous.
- Speed1P  in  2  LINK1000# per port, active low, asynchronous.
- Speed2P  in  2  LINK100# per port, active low, asynchronous.
- IntEn  in  1  interrupt enable.
- IntClr  in  2  per-port write-1-to-clear pulse for LinkChg.
- LinkSpeed  out  4  [2p+1:2p] for port p: 00 no link/10BaseT, 01 100BaseT, 10 1000BaseT, 11 invalid code.
- LinkUp  out  2  debounced link present at 100 or 1000.
- ActSeen  out  2  stretched activity, valid only while LinkUp.
- LinkChg  out  2  sticky debounced-change flag per port.
- LinkIrq  out  1  IntEn & |LinkChg.

## Operation
- Each of the 6 pins passes through a 2-flop synchroniser, sync_q.
- Per-port code = {Speed1P, Speed2P} after sync. Decode: 01 → LinkSpeed 10, LinkUp 1; 10 → 01, LinkUp 1; 11 → 00, LinkUp 0; 00 → 11 (invalid), LinkUp 0.
- Debounce per port uses cand (2b), cnt ($clog2(DEB_CNT) bits) and stable (2b). Each cycle, in priority order:
  - sync code ≠ cand: cand ← code, cnt ← 0.
  - Otherwise, cnt < DEB_CNT−1: cnt ← cnt+1.
  - Otherwise (cnt == DEB_CNT−1, saturated): if cand ≠ stable, then stable ← cand and the LinkChg set event fires.
- LinkSpeed and LinkUp are decoded from stable and registered with it.
- Glitches shorter than DEB_CNT cycles never reach stable. A glitch that returns to the original code restarts cnt but causes no change.
- Activity per port uses an act counter ($clog2(ACT_HOLD+1) bits).
  - Synced ACT# low: load ACT_HOLD.
  - Else, nonzero: decrement.
  - ActSeen = (act ≠ 0) & LinkUp, registered.
  - With link down, the counter still runs but ActSeen stays 0.
- LinkChg[p]: set on a stable update, cleared by IntClr[p]. Simultaneous set and clear gives set.
- ALL_PWRGD low (synchronously sampled, no synchroniser):
  - stable forced to 11.
  - cand ← 11, cnt ← 0, act ← 0.
  - No LinkChg set.
  - IntClr still honoured.
- On ALL_PWRGD rising, debounce restarts from cand = 11.
- Reset gives the same state as PWRGD low, plus LinkChg ← 0 and sync flops ← 1.
- Reset values of outputs: LinkSpeed 0000, LinkUp 00, ActSeen 00, LinkChg 00, LinkIrq 0.

## Timing
- Pin change to sync_q: 2 edges. Pin change to cand: 3 edges.
- Pin change to LinkSpeed/LinkUp/LinkChg: DEB_CNT+3 edges, if the pins are held steady throughout.
- LinkIrq is combinational from the LinkChg and IntEn flops, with zero added latency.
- ACT# low at edge k: act loaded at k+3, ActSeen high at k+4.
- Last ACT# low sample at edge k: ActSeen falls at k+ACT_HOLD+4.
- IntClr sampled at edge k clears LinkChg at that edge. The output is low from k onward unless a set coincides.
- Reset or PWRGD low mid-debounce aborts with no commit. The next commit requires a full DEB_CNT window.
- Ports are fully independent. Simultaneous commits on both ports set both LinkChg bits in the same cycle.

## Test plan
Directed tests use DEB_CNT=8, ACT_HOLD=20, IntEn=1.
- Reset, then drive port0 code 01 steadily → LinkSpeed[1:0]=10, LinkUp[0]=1, LinkChg=01, LinkIrq=1, all exactly 11 edges after the pin change. Port1 unchanged.
- Port1 code 11→10 with a 5-cycle glitch back to 11 at cycle 4 → no commit during the glitch. Commit 01/LinkUp[1]=1 occurs 11 edges after the final change.
- Port0 at 1000 link, ACT# low 1 cycle at edge k → ActSeen[0] high at k+4, low at k+24. Repeating pulses every 10 cycles keep ActSeen high continuously.
- LinkChg[0] set at the same edge IntClr[0] pulses → LinkChg[0] stays 1. A later IntClr[0] → 0, and LinkIrq drops the same cycle. IntEn=0 masks LinkIrq with LinkChg held.
- Port0 at 100 link, drop ALL_PWRGD → next edge LinkSpeed=0000, LinkUp=00, ActSeen=00, LinkChg unchanged. Raise PWRGD with code 10 held → commit after DEB_CNT+1 edges, LinkChg set.
- Code 00 held → LinkSpeed[1:0]=11, LinkUp[0]=0, ActSeen[0]=0 despite ACT# low. Assert Reset mid-debounce → all outputs zero next edge.
